// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory request/response, decode handshake and redirect.
// master = fetch unit side, slave = memory/decode/branch side.
interface instruction_fetch_unit_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_req;
    logic [31:0]       imem_rdata;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] pc_out;
    logic              instr_valid;
    logic              instr_ready;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_target;

    modport master (
        output imem_addr, imem_req, instr, pc_out, instr_valid,
        input  imem_rdata, instr_ready, redirect_valid, redirect_target
    );

    modport slave (
        input  imem_addr, imem_req, instr, pc_out, instr_valid,
        output imem_rdata, instr_ready, redirect_valid, redirect_target
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// PC owner and fetch sequencer for a fixed-latency instruction memory.
// Optional PREDECODE_JUMP_EN: J-format words (opcode 000010) steer the PC at capture.
module instruction_fetch_unit #(
    parameter int                ADDR_W       = 5,
    parameter int                IMEM_LATENCY = 4,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    instruction_fetch_unit_if.master    bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    localparam logic [3:0] CNT_INIT = 4'(IMEM_LATENCY - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic              req_q;
    logic [31:0]       instr_q;
    logic [ADDR_W-1:0] pc_out_q;
    logic              valid_q;
    logic [3:0]        cnt_q;

    // PC that follows a successful capture.
    always_comb begin
        pc_d = pc_q + ADDR_W'(1);
`ifdef PREDECODE_JUMP_EN
        if (bus.imem_rdata[31:26] == 6'b000010)
            pc_d = bus.imem_rdata[ADDR_W-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            req_q    <= 1'b0;
            instr_q  <= '0;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
        end else if (state_q != S_IDLE && bus.redirect_valid) begin
            // Redirect beats capture and handshake; any in-flight data is dropped.
            pc_q    <= bus.redirect_target;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            state_q <= S_REQ;
        end else begin
            case (state_q)
                S_IDLE: begin
                    req_q   <= 1'b1;
                    state_q <= S_REQ;
                end
                S_REQ: begin
                    req_q   <= 1'b0;
                    cnt_q   <= CNT_INIT;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        instr_q  <= bus.imem_rdata;
                        pc_out_q <= pc_q;
                        valid_q  <= 1'b1;
                        pc_q     <= pc_d;
                        state_q  <= S_HOLD;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_HOLD: begin
                    if (bus.instr_ready) begin
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        state_q <= S_REQ;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.imem_req    = req_q;
    assign bus.instr       = instr_q;
    assign bus.pc_out      = pc_out_q;
    assign bus.instr_valid = valid_q;
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch-side consumer of the instruction memory. It owns the PC and drives the read address/request into the fixed-latency instruction memory. It captures the returned word and presents it to decode over a valid/ready handshake. It accepts PC redirects (branch/jump resolved downstream) and discards any fetch still in flight when one arrives.

Parameters:
ADDR_W, 5, instruction address width in words; PC wraps modulo 2^ADDR_W
IMEM_LATENCY, 4, cycles from the end of the request cycle until imem_rdata is valid; legal range 1..15
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
imem_addr  output  ADDR_W  word address to instruction memory
imem_req  output  1  high for exactly one cycle per fetch
imem_rdata  input  32  instruction word from memory
instr  output  32  fetched instruction to decode
pc_out  output  ADDR_W  address that instr was fetched from
instr_valid  output  1  instr/pc_out hold a valid instruction
instr_ready  input  1  decode accepts instr this cycle
redirect_valid  input  1  replace PC, flush the in-flight fetch
redirect_target  input  ADDR_W  new PC

Behaviour:
- Reset (async assert, sync release): state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr=0, pc_out=0, instr_valid=0, wait counter=0.
- All outputs are registered. imem_req=1 only in state REQ. imem_addr=pc at all times.
- IDLE: on the first rising edge with rst_n high, go to REQ.
- REQ (1 cycle): imem_req=1, imem_addr=pc. On the next edge, go to WAIT and load cnt=IMEM_LATENCY-1.
- WAIT: decrement cnt each cycle.
  - At the edge where cnt==0: instr<=imem_rdata, pc_out<=pc, instr_valid<=1, pc<=pc+1 (mod 2^ADDR_W), go to HOLD.
  - Request-to-valid is IMEM_LATENCY+1 cycles.
- HOLD: instr, pc_out and instr_valid stay stable while instr_ready=0. No new request is issued.
  - Handshake = instr_valid & instr_ready at an edge: clear instr_valid, go to REQ.
  - Throughput: one instruction per IMEM_LATENCY+2 cycles.
- Redirect (any state except IDLE):
  - On an edge with redirect_valid=1: pc<=redirect_target, instr_valid<=0, go to REQ.
  - Any outstanding WAIT capture is abandoned and the memory data is ignored.
  - Redirect has priority over a capture and over a handshake in the same cycle; no pc+1 is applied.
  - Redirect in REQ: the request already issued is discarded; a new REQ follows.
- Wrap-around: pc=2^ADDR_W-1 increments to 0 with no flag.
- Reset mid-operation: returns immediately to reset values; a partially waited fetch is lost.
- instr_ready while instr_valid=0 is ignored.
- State encoding is free. The bench observes only the ports.

Optional Feature:
PREDECODE_JUMP_EN
- Defined: at capture, if imem_rdata[31:26]==6'b000010 (J), pc<=imem_rdata[ADDR_W-1:0] instead of pc+1. The J word is still delivered to decode unchanged. A redirect in the same cycle still wins.
- Undefined: capture always does pc<=pc+1; jumps rely on redirect_valid.

Test Plan:
1. Reset, memory preloaded with mem[0]=0x20010003 and mem[1]=0x20020003, instr_ready=1 -> the first imem_req cycle has addr 0. instr_valid rises 5 cycles later with instr=0x20010003 and pc_out=0. The next imem_req has addr 1.
2. instr_ready=0 for 10 cycles while instr_valid=1 -> instr/pc_out stay stable and no imem_req occurs. Set instr_ready=1 -> exactly one handshake, then imem_req with addr pc_out+1.
3. redirect_valid=1 with target 20 during the 2nd WAIT cycle of the fetch to addr 2 -> the mem[2] data is never presented. The next imem_req has addr 20. instr_valid stays 0 until the addr-20 word arrives.
4. redirect_valid=1 with target 7 in the same cycle as the handshake of pc_out=3 -> the next imem_req has addr 7, not 4.
5. redirect to 31, accept the instruction -> the next imem_req has addr 0 (wrap).
6. mem[5]=0x0B145162 (J) -> with PREDECODE_JUMP_EN, after accepting pc_out=5 the next imem_req has addr 2. Without the macro it has addr 6. Also assert rst_n low mid-WAIT -> all outputs return to reset values immediately.
